// File: rtl/multi_rate_tick_gen_pkg.sv
// Shared constants and helpers for the multi-rate tick generator.
package multi_rate_tick_gen_pkg;

    // System clock feeding the timing path
    localparam int unsigned CLK_HZ = 100_000_000;

    // Divisor that yields the requested output frequency from CLK_HZ
    function automatic int unsigned div_from_hz(input int unsigned hz);
        return CLK_HZ / hz;
    endfunction

    localparam int unsigned DIV_1HZ   = div_from_hz(1);
    localparam int unsigned DIV_500HZ = div_from_hz(500);

    // Per-channel operating mode, decoded each cycle from divisor and enable
    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,   // divisor is zero: channel idle
        CH_RUN  = 2'd1,   // counting
        CH_HOLD = 2'd2    // global enable low: phase frozen
    } ch_mode_e;

endpackage

// File: rtl/multi_rate_tick_gen_tick_channel.sv
// One rate channel: counter, active divisor, shadow divisor with pending flag,
// and the registered tick / square-wave outputs.
module tick_channel
    import multi_rate_tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = 27,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sync_clr_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wdata_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pend_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wrap;
    logic             apply;
    ch_mode_e         mode;

    // Next-state: counting, period-aligned divisor apply, shadow/pending update
    always_comb begin
        wrap  = (cnt_q == div_q - CNT_W'(1));
        apply = pend_q && (sync_clr_i || (div_q == '0) || (en_i && wrap));

        if (div_q == '0) begin
            mode = CH_OFF;
        end else if (en_i) begin
            mode = CH_RUN;
        end else begin
            mode = CH_HOLD;
        end

        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        sq_d     = sq_q;

        if (apply) begin
            div_d = shadow_q;
        end

        if (sync_clr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else begin
            case (mode)
                CH_OFF: begin
                    cnt_d = '0;
                    sq_d  = 1'b0;
                end
                CH_RUN: begin
                    if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // On a wrap the new period already follows the applied divisor
                    sq_d = (div_d != '0) && (cnt_d >= (div_d >> 1));
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end

        // A write on the apply edge stays pending; the old shadow is what applies
        if (wr_i) begin
            shadow_d = wdata_i;
            pend_d   = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end
    end

    // State registers with asynchronous reset to the default divisor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            div_q    <= RST_DIV;
            shadow_q <= RST_DIV;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// N-channel rate generator: per-channel tick enables and square waves on clk,
// runtime-programmable divisors, global enable and synchronous restart.
module multi_rate_tick_gen
    import multi_rate_tick_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 27,
    parameter int unsigned CH_W   = 4,
    parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV =
        {CNT_W'(DIV_500HZ), CNT_W'(DIV_1HZ)}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] sq_o,
    output logic [NUM_CH-1:0] pend_o
);

    logic [NUM_CH-1:0] wr_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel indices match no channel and are dropped
        assign wr_ch[i] = cfg_wr && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (DEFAULT_DIV[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en),
            .sync_clr_i (sync_clr),
            .wr_i       (wr_ch[i]),
            .wdata_i    (cfg_div),
            .tick_o     (tick_o[i]),
            .sq_o       (sq_o[i]),
            .pend_o     (pend_o[i])
        );
    end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Directed bench for multi_rate_tick_gen (2 channels, 8-bit, defaults 5 / 3).
module tb_multi_rate_tick_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sync_clr = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic [1:0] tick_o, sq_o, pend_o;

    typedef struct {
        string      nm;
        logic [5:0] v;   // {tick[1:0], sq[1:0], pend[1:0]}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    multi_rate_tick_gen #(
        .NUM_CH      (2),
        .CNT_W       (8),
        .CH_W        (4),
        .DEFAULT_DIV ({8'd3, 8'd5})
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .tick_o   (tick_o),
        .sq_o     (sq_o),
        .pend_o   (pend_o)
    );

    always #5 clk = ~clk;

    task automatic push(input string nm, input logic [5:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    // Hold inputs for t0.len() cycles; strings give per-cycle expected outputs
    task automatic seg(input string nm, input logic e, input logic sc, input logic w,
                       input logic [3:0] ch, input logic [7:0] d,
                       input string t0, input string s0, input string t1, input string s1,
                       input logic [1:0] p);
        en = e; sync_clr = sc; cfg_wr = w; cfg_ch = ch; cfg_div = d;
        for (int i = 0; i < t0.len(); i++) begin
            logic [1:0] t, s;
            t = {t1[i] == "1", t0[i] == "1"};
            s = {s1[i] == "1", s0[i] == "1"};
            @(posedge clk);
            #1;
            push(nm, {t, s, p});
        end
        sync_clr = 1'b0; cfg_wr = 1'b0;
    endtask

    // Monitor: outputs are sampled on the falling edge, one expectation per cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({tick_o, sq_o, pend_o} !== e.v) begin
                    errors++;
                    $display("FAIL %s @%0t: tick/sq/pend got %b/%b/%b expected %b/%b/%b",
                             e.nm, $time, tick_o, sq_o, pend_o, e.v[5:4], e.v[3:2], e.v[1:0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) begin
            @(posedge clk);
            #1;
            push("reset", 6'b0);
        end
        rst = 1'b0;

        // Free run from reset: ch0 period 5, ch1 period 3
        seg("run", 1, 0, 0, 0, 0, "000010000100001", "011100111001110",
            "001001001001001", "110110110110110", 2'b00);

        // Enable low mid-period: phase frozen, ticks resume on schedule
        seg("pre_hold", 1, 0, 0, 0, 0, "00", "01", "00", "11", 2'b00);
        seg("hold", 0, 0, 0, 0, 0, "0000000", "1111111", "0000000", "1111111", 2'b00);
        seg("resume", 1, 0, 0, 0, 0, "0010000100", "1100111001",
            "1001001001", "0110110110", 2'b00);

        // Two writes to ch0 before the wrap: last one (4) applies at the wrap
        seg("align", 1, 0, 0, 0, 0, "001", "110", "001", "110", 2'b00);
        seg("pre_wr", 1, 0, 0, 0, 0, "0", "0", "0", "1", 2'b00);
        seg("wr8", 1, 0, 1, 0, 8, "0", "1", "0", "1", 2'b01);
        seg("mid", 1, 0, 0, 0, 0, "0", "1", "1", "0", 2'b01);
        seg("wr4", 1, 0, 1, 0, 4, "0", "1", "0", "1", 2'b01);
        seg("wrap_apply", 1, 0, 0, 0, 0, "1", "0", "0", "1", 2'b00);
        seg("div4", 1, 0, 0, 0, 0, "00010001", "01100110", "10010010", "01101101", 2'b00);

        // ch1 switched off at its wrap, then on again with immediate apply
        seg("wr_off", 1, 0, 1, 1, 0, "0", "0", "0", "1", 2'b10);
        seg("off_apply", 1, 0, 0, 0, 0, "0", "1", "1", "0", 2'b00);
        seg("idle", 1, 0, 0, 0, 0, "010", "100", "000", "000", 2'b00);
        seg("wr2", 1, 0, 1, 1, 2, "0", "1", "0", "0", 2'b10);
        seg("on_apply", 1, 0, 0, 0, 0, "0", "1", "0", "0", 2'b00);
        seg("div2", 1, 0, 0, 0, 0, "100010", "001100", "010101", "101010", 2'b00);

        // sync_clr with both channels pending (6 and 3)
        seg("wr6", 1, 0, 1, 0, 6, "0", "1", "0", "1", 2'b01);
        seg("wr3_at_wrap", 1, 0, 1, 1, 3, "0", "1", "1", "0", 2'b11);
        seg("sclr", 1, 1, 0, 0, 0, "0", "0", "0", "0", 2'b00);
        seg("post_clr", 1, 0, 0, 0, 0, "0000010", "0011100", "0010010", "1101101", 2'b00);

        // Write landing on a wrap with a divisor already pending
        seg("wr2b", 1, 0, 1, 0, 2, "0", "0", "0", "1", 2'b01);
        seg("run6", 1, 0, 0, 0, 0, "000", "111", "100", "011", 2'b01);
        seg("wrap_wr", 1, 0, 1, 0, 3, "1", "0", "1", "0", 2'b01);
        seg("div2b", 1, 0, 0, 0, 0, "0", "1", "0", "1", 2'b01);
        seg("apply3", 1, 0, 0, 0, 0, "1", "0", "0", "1", 2'b00);
        seg("div3", 1, 0, 0, 0, 0, "001", "110", "100", "011", 2'b00);

        // Asynchronous reset between edges, with ch0 pending
        seg("wr7", 1, 0, 1, 0, 7, "0", "1", "1", "0", 2'b01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push("async_rst", 6'b0);
        @(posedge clk);
        #1;
        push("rst_hold", 6'b0);
        rst = 1'b0;

        // Defaults restored; write to nonexistent channel 3 has no effect
        seg("ign_wr", 1, 0, 1, 3, 1, "0", "0", "0", "1", 2'b00);
        seg("restored", 1, 0, 0, 0, 0, "00010000100001", "11100111001110",
            "01001001001001", "10110110110110", 2'b00);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: pending expectations got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
